// File: rtl/mem_burst_arbiter.sv
// Round-robin burst arbiter that shares one synchronous-read memory port between NREQ requesters.
// Optional macro WRITE_PRIORITY_EN: write bursts win arbitration over read bursts.
module mem_burst_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 6,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*LEN_W-1:0]    req_len,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic                     beat_ack,
  output logic [NREQ-1:0]          burst_done,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_ren,
  output logic                     mem_wen,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rdata_valid,
  output logic [ID_W-1:0]          rdata_id,
  output logic                     busy,
  output logic                     state_dbg
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt_idx;
  logic [LEN_W-1:0]  beat_cnt;
  logic [LEN_W-1:0]  len_l;

  logic [NREQ-1:0]   cand;
  logic              sel_found;
  logic [ID_W-1:0]   sel_idx;
  logic [LEN_W-1:0]  sel_len;
  logic [LEN_W-1:0]  len_n;
  logic              last_beat;

  // Pick the first candidate at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    cand      = req;
`ifdef WRITE_PRIORITY_EN
    if (|(req & req_we)) cand = req & req_we;
`endif
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!sel_found && cand[idx]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(idx);
      end
    end
  end

  assign sel_len   = req_len[sel_idx*LEN_W +: LEN_W];
  assign len_n     = (sel_len == '0) ? LEN_W'(1) : sel_len;
  assign last_beat = (beat_cnt == len_l - LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gnt_idx     <= '0;
      beat_cnt    <= '0;
      len_l       <= '0;
      gnt         <= '0;
      beat_ack    <= 1'b0;
      burst_done  <= '0;
      mem_addr    <= '0;
      mem_ren     <= 1'b0;
      mem_wen     <= 1'b0;
      rdata_valid <= 1'b0;
      rdata_id    <= '0;
    end else begin
      rdata_valid <= mem_ren;
      rdata_id    <= gnt_idx;
      case (state)
        IDLE: begin
          if (sel_found) begin
            state      <= BURST;
            gnt_idx    <= sel_idx;
            len_l      <= len_n;
            beat_cnt   <= '0;
            gnt        <= NREQ'(1) << sel_idx;
            beat_ack   <= 1'b1;
            mem_addr   <= req_addr[sel_idx*ADDR_W +: ADDR_W];
            mem_wen    <= req_we[sel_idx];
            mem_ren    <= ~req_we[sel_idx];
            burst_done <= (len_n == LEN_W'(1)) ? (NREQ'(1) << sel_idx) : '0;
          end
        end
        BURST: begin
          if (last_beat) begin
            state      <= IDLE;
            rr_ptr     <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            beat_cnt   <= '0;
            gnt        <= '0;
            beat_ack   <= 1'b0;
            burst_done <= '0;
            mem_addr   <= '0;
            mem_wen    <= 1'b0;
            mem_ren    <= 1'b0;
          end else begin
            beat_cnt   <= beat_cnt + LEN_W'(1);
            mem_addr   <= mem_addr + ADDR_W'(1);
            // Announce completion together with the beat that will be last.
            burst_done <= (beat_cnt + LEN_W'(2) == len_l) ? gnt : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_wdata = mem_wen ? req_wdata[gnt_idx*DATA_W +: DATA_W] : '0;
  assign rdata     = rdata_valid ? mem_rdata : '0;
  assign busy      = (state == BURST);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Self-checking bench for mem_burst_arbiter: per-scenario tasks plus a read-data scoreboard.
module tb_mem_burst_arbiter;
  localparam int NREQ = 3, ADDR_W = 16, DATA_W = 8, LEN_W = 6, ID_W = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req, req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*LEN_W-1:0]  req_len;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        gnt, burst_done;
  logic                   beat_ack, mem_ren, mem_wen, rdata_valid, busy, state_dbg;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata, rdata;
  logic [DATA_W-1:0]      mem_rdata = '0;
  logic [ID_W-1:0]        rdata_id;

  logic [ID_W+DATA_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  wire [44:0] out_vec = {gnt, beat_ack, burst_done, mem_ren, mem_wen, busy, rdata_valid,
                         rdata_id, mem_addr, mem_wdata, rdata};

  mem_burst_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .beat_ack(beat_ack),
    .burst_done(burst_done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_rdata(mem_rdata), .rdata(rdata),
    .rdata_valid(rdata_valid), .rdata_id(rdata_id), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // synchronous-read memory model
  always @(posedge clk) if (mem_ren) mem_rdata <= pat(mem_addr);

  // scoreboard for returned read data
  always @(negedge clk) begin
    if (!rst && rdata_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rdata_unexpected got id=%0d data=%h, required none", rdata_id, rdata);
      end else begin
        logic [ID_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({rdata_id, rdata} !== e) begin
          n_fail++;
          $display("FAIL rdata got id=%0d data=%h, required id=%0d data=%h",
                   rdata_id, rdata, e[DATA_W +: ID_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic push_read(input int id, input logic [15:0] base, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back({2'(id), pat(base + 16'(i))});
  endtask

  task automatic set_req(input int id, input logic we, input logic [15:0] addr, input int len);
    req[id] = 1'b1;
    req_we[id] = we;
    req_addr[id*ADDR_W +: ADDR_W] = addr;
    req_len[id*LEN_W +: LEN_W] = 6'(len);
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_drained(input string name);
    repeat (2) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain got %0d pending reads, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (out_vec !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h, required 0", out_vec);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || gnt !== '0) begin
      n_fail++;
      $display("FAIL reset_idle got busy=%b gnt=%b, required busy=0 gnt=000", busy, gnt);
    end
  endtask

  task automatic test_read_burst();
    logic [15:0] ea;
    push_read(0, 16'h0100, 9);
    set_req(0, 1'b0, 16'h0100, 9);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) req[0] = 1'b0;
      ea = 16'h0100 + 16'(i);
      n_tests++;
      if (gnt !== 3'b001 || mem_addr !== ea || mem_ren !== 1'b1 || mem_wen !== 1'b0 ||
          beat_ack !== 1'b1 || burst_done !== ((i == 8) ? 3'b001 : 3'b000)) begin
        n_fail++;
        $display("FAIL read_beat%0d got gnt=%b addr=%h ren=%b wen=%b ack=%b done=%b, required gnt=001 addr=%h ren=1 wen=0 ack=1 done=%b",
                 i, gnt, mem_addr, mem_ren, mem_wen, beat_ack, burst_done, ea, (i == 8) ? 3'b001 : 3'b000);
      end
    end
    @(negedge clk);
    n_tests++;
    if (gnt !== '0 || busy !== 1'b0 || mem_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL read_idle got gnt=%b busy=%b ren=%b, required 000 0 0", gnt, busy, mem_ren);
    end
    check_drained("read_burst");
  endtask

  task automatic test_round_robin();
    logic [15:0] bases[3];
    logic [2:0]  eg;
    bases = '{16'h0200, 16'h0300, 16'h0400};
    do_reset();
    for (int s = 0; s < 3; s++) begin
      set_req(s, 1'b0, bases[s], 2);
      push_read(s, bases[s], 2);
    end
    for (int t = 0; t < 9; t++) begin
      int slot, ph;
      slot = t / 3;
      ph = t % 3;
      @(negedge clk);
      n_tests++;
      if (ph < 2) begin
        if (ph == 0) req[slot] = 1'b0;
        eg = 3'b001 << slot;
        if (gnt !== eg || mem_addr !== bases[slot] + 16'(ph) || busy !== 1'b1 ||
            burst_done !== ((ph == 1) ? eg : 3'b000)) begin
          n_fail++;
          $display("FAIL rr_t%0d got gnt=%b addr=%h done=%b, required gnt=%b addr=%h done=%b",
                   t, gnt, mem_addr, burst_done, eg, bases[slot] + 16'(ph), (ph == 1) ? eg : 3'b000);
        end
      end else if (gnt !== '0 || busy !== 1'b0 || burst_done !== '0) begin
        n_fail++;
        $display("FAIL rr_gap%0d got gnt=%b busy=%b done=%b, required 000 0 000", t, gnt, busy, burst_done);
      end
    end
    set_req(0, 1'b0, 16'h0800, 1);
    set_req(2, 1'b0, 16'h0900, 1);
    push_read(0, 16'h0800, 1);
    push_read(2, 16'h0900, 1);
    @(negedge clk);
    req[0] = 1'b0;
    n_tests++;
    if (gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL rr_wrap_first got gnt=%b, required 001", gnt);
    end
    repeat (2) @(negedge clk);
    req[2] = 1'b0;
    n_tests++;
    if (gnt !== 3'b100) begin
      n_fail++;
      $display("FAIL rr_wrap_second got gnt=%b, required 100", gnt);
    end
    check_drained("round_robin");
  endtask

  task automatic test_write_wrap();
    logic [15:0] ea;
    logic [7:0]  ew;
    req_wdata[2*DATA_W +: DATA_W] = 8'hA0;
    set_req(2, 1'b1, 16'hFFFE, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) req[2] = 1'b0;
      ea = 16'hFFFE + 16'(i);
      ew = 8'hA0 + 8'(i);
      n_tests++;
      if (gnt !== 3'b100 || mem_addr !== ea || mem_wen !== 1'b1 || mem_ren !== 1'b0 ||
          mem_wdata !== ew || burst_done !== ((i == 3) ? 3'b100 : 3'b000)) begin
        n_fail++;
        $display("FAIL write_beat%0d got gnt=%b addr=%h wen=%b ren=%b wdata=%h done=%b, required gnt=100 addr=%h wen=1 ren=0 wdata=%h done=%b",
                 i, gnt, mem_addr, mem_wen, mem_ren, mem_wdata, burst_done, ea, ew, (i == 3) ? 3'b100 : 3'b000);
      end
      if (beat_ack) req_wdata[2*DATA_W +: DATA_W] = ew + 8'h01;
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || mem_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL write_idle got busy=%b wen=%b, required 0 0", busy, mem_wen);
    end
    check_drained("write_wrap");
  endtask

  task automatic test_len_zero();
    set_req(1, 1'b0, 16'h0500, 0);
    push_read(1, 16'h0500, 1);
    @(negedge clk);
    req[1] = 1'b0;
    n_tests++;
    if (gnt !== 3'b010 || mem_addr !== 16'h0500 || mem_ren !== 1'b1 || burst_done !== 3'b010) begin
      n_fail++;
      $display("FAIL len0_beat got gnt=%b addr=%h ren=%b done=%b, required 010 0500 1 010",
               gnt, mem_addr, mem_ren, burst_done);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || gnt !== '0 || burst_done !== '0) begin
      n_fail++;
      $display("FAIL len0_after got busy=%b gnt=%b done=%b, required 0 000 000", busy, gnt, burst_done);
    end
    check_drained("len_zero");
  endtask

  task automatic test_back_to_back();
    set_req(1, 1'b0, 16'h0A00, 3);
    push_read(1, 16'h0A00, 3);
    push_read(1, 16'h0A00, 3);
    for (int t = 0; t < 8; t++) begin
      int ph;
      ph = t % 4;
      @(negedge clk);
      if (t == 4) req[1] = 1'b0;
      n_tests++;
      if (ph < 3) begin
        if (gnt !== 3'b010 || mem_addr !== 16'h0A00 + 16'(ph) ||
            burst_done !== ((ph == 2) ? 3'b010 : 3'b000)) begin
          n_fail++;
          $display("FAIL b2b_t%0d got gnt=%b addr=%h done=%b, required gnt=010 addr=%h done=%b",
                   t, gnt, mem_addr, burst_done, 16'h0A00 + 16'(ph), (ph == 2) ? 3'b010 : 3'b000);
        end
      end else if (busy !== 1'b0 || gnt !== '0) begin
        n_fail++;
        $display("FAIL b2b_gap%0d got busy=%b gnt=%b, required 0 000", t, busy, gnt);
      end
    end
    check_drained("back_to_back");
  endtask

  task automatic test_reset_mid_burst();
    set_req(1, 1'b0, 16'h0600, 8);
    push_read(1, 16'h0600, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) req[1] = 1'b0;
      n_tests++;
      if (gnt !== 3'b010 || mem_addr !== 16'h0600 + 16'(i) || mem_ren !== 1'b1) begin
        n_fail++;
        $display("FAIL rstmid_beat%0d got gnt=%b addr=%h ren=%b, required 010 %h 1",
                 i, gnt, mem_addr, mem_ren, 16'h0600 + 16'(i));
      end
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (out_vec !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got %h, required 0", out_vec);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || burst_done !== '0 || mem_ren !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_quiet%0d got busy=%b done=%b ren=%b, required 0 000 0",
                 i, busy, burst_done, mem_ren);
      end
    end
    check_drained("reset_mid");
    set_req(0, 1'b0, 16'h0C00, 1);
    set_req(2, 1'b0, 16'h0D00, 1);
    push_read(0, 16'h0C00, 1);
    push_read(2, 16'h0D00, 1);
    @(negedge clk);
    req[0] = 1'b0;
    n_tests++;
    if (gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL rstmid_next_grant got gnt=%b, required 001", gnt);
    end
    repeat (2) @(negedge clk);
    req[2] = 1'b0;
    check_drained("reset_mid_next");
  endtask

  task automatic test_write_priority();
    int first, second;
`ifdef WRITE_PRIORITY_EN
    first = 2; second = 1;
`else
    first = 1; second = 2;
`endif
    do_reset();
    set_req(1, 1'b0, 16'h0700, 1);
    set_req(2, 1'b1, 16'h0010, 1);
    push_read(1, 16'h0700, 1);
    @(negedge clk);
    req[first] = 1'b0;
    n_tests++;
    if (gnt !== (3'b001 << first)) begin
      n_fail++;
      $display("FAIL prio_first got gnt=%b, required %b", gnt, 3'b001 << first);
    end
    repeat (2) @(negedge clk);
    req[second] = 1'b0;
    n_tests++;
    if (gnt !== (3'b001 << second)) begin
      n_fail++;
      $display("FAIL prio_second got gnt=%b, required %b", gnt, 3'b001 << second);
    end
    check_drained("write_priority");
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_round_robin();
    test_write_wrap();
    test_len_zero();
    test_back_to_back();
    test_reset_mid_burst();
    test_write_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
